// File: rtl/scroll_pkg.sv
// Shared types and constants for the scrolling 7-segment display consumer.
package scroll_pkg;

  typedef logic [4:0] char_code_t;

  localparam char_code_t CHAR_BLANK = 5'd16;
  localparam char_code_t CHAR_DASH  = 5'd17;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_REQUEST,
    S_CAPTURE
  } state_t;

endpackage

// File: rtl/scroll_display_ctrl_seg7_decode.sv
// Character code to active-low 7-segment pattern, bits [6:0] = g..a.
module seg7_decode
  import scroll_pkg::*;
(
  input  char_code_t code,
  output logic [6:0] segs
);

  always_comb begin
    segs = SEG_BLANK;
    case (code)
      5'd0:      segs = 7'h40;
      5'd1:      segs = 7'h79;
      5'd2:      segs = 7'h24;
      5'd3:      segs = 7'h30;
      5'd4:      segs = 7'h19;
      5'd5:      segs = 7'h12;
      5'd6:      segs = 7'h02;
      5'd7:      segs = 7'h78;
      5'd8:      segs = 7'h00;
      5'd9:      segs = 7'h10;
      5'd10:     segs = 7'h08;
      5'd11:     segs = 7'h03;
      5'd12:     segs = 7'h46;
      5'd13:     segs = 7'h21;
      5'd14:     segs = 7'h06;
      5'd15:     segs = 7'h0E;
      CHAR_DASH: segs = 7'h3F;
      default:   segs = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/scroll_display_ctrl.sv
// Pulls characters from the scroll buffer on a timer or on demand and shifts
// them right-to-left across NUM_DIGITS active-low 7-segment displays.
module scroll_display_ctrl
  import scroll_pkg::*;
#(
  parameter int NUM_DIGITS    = 6,
  parameter int SCROLL_PERIOD = 25_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    step,
  input  logic                    clear,
  output logic                    next_char,
  input  logic [4:0]              hex_char,
  output logic [NUM_DIGITS*7-1:0] hex_segs,
  output logic                    busy
);

  localparam int CNT_W = $clog2(SCROLL_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCROLL_PERIOD - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  char_code_t       digit_q [NUM_DIGITS];
  char_code_t       digit_d [NUM_DIGITS];
  logic             tick;

  assign tick = (state_q == S_WAIT) && (cnt_q == CNT_LAST);
  assign busy = (state_q == S_REQUEST) || (state_q == S_CAPTURE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    digit_d   = digit_q;
    next_char = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (step)        state_d = S_REQUEST;
        else if (enable) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tick || step) begin
          state_d = S_REQUEST;
          cnt_d   = '0;
        end else if (!enable) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_REQUEST: begin
        next_char = 1'b1;
        state_d   = S_CAPTURE;
      end
      S_CAPTURE: begin
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
          digit_d[i] = digit_q[i-1];
        end
        digit_d[0] = hex_char;
        state_d    = enable ? S_WAIT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Clear overrides everything, including a strobe or capture in flight.
    if (clear) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_d[i] = CHAR_BLANK;
      end
      cnt_d     = '0;
      next_char = 1'b0;
      state_d   = enable ? S_WAIT : S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_q[i] <= CHAR_BLANK;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_q[i] <= digit_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .code (digit_q[g]),
      .segs (hex_segs[g*7 +: 7])
    );
  end

endmodule

// File: tb/tb_scroll_display_ctrl.sv
// Self-checking bench: buffer model feeds codes, strobe cycles are scoreboarded.
module tb_scroll_display_ctrl;

  localparam int ND = 6;
  localparam int SP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          step;
  logic          clear;
  logic          next_char;
  logic [4:0]    hex_char;
  logic [ND*7-1:0] hex_segs;
  logic          busy;

  int nChecks = 0;
  int nPass   = 0;
  int cyc     = 0;

  int bufQ[$];
  int expStrobeQ[$];
  int obsStrobeQ[$];

  localparam logic [6:0] B = 7'h7F;

  scroll_display_ctrl #(
    .NUM_DIGITS    (ND),
    .SCROLL_PERIOD (SP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .step      (step),
    .clear     (clear),
    .next_char (next_char),
    .hex_char  (hex_char),
    .hex_segs  (hex_segs),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer model: registered read, data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (rst) begin
      hex_char <= 5'd0;
    end else if (next_char) begin
      if (bufQ.size() > 0) hex_char <= 5'(bufQ.pop_front());
      else                 hex_char <= 5'd0;
    end
  end

  always @(negedge clk) begin
    if (!rst && next_char) obsStrobeQ.push_back(cyc);
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("[TB] FAIL %s: observed 0x%0h, required 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic applyStimulus(input logic e, input logic s, input logic c);
    enable = e;
    step   = s;
    clear  = c;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drainScoreboard(input string tag);
    int e;
    while (expStrobeQ.size() > 0) begin
      e = expStrobeQ.pop_front();
      if (obsStrobeQ.size() == 0) checkOutput({tag, "_strobe_missing"}, 64'hFFFF_FFFF, 64'(e));
      else                        checkOutput({tag, "_strobe_cycle"}, 64'(obsStrobeQ.pop_front()), 64'(e));
    end
    checkOutput({tag, "_strobe_extra"}, 64'(obsStrobeQ.size()), 64'd0);
    obsStrobeQ.delete();
  endtask

  function automatic logic [ND*7-1:0] segs6(input logic [6:0] d5, d4, d3, d2, d1, d0);
    return {d5, d4, d3, d2, d1, d0};
  endfunction

  initial begin
    int k;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(3);
    checkOutput("reset_next_char", 64'(next_char), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_segs", 64'(hex_segs), 64'(segs6(B, B, B, B, B, B)));
    rst = 1'b0;

    // Idle with enable low: nothing happens.
    waitCycles(20);
    checkOutput("idle_segs", 64'(hex_segs), 64'(segs6(B, B, B, B, B, B)));
    checkOutput("idle_busy", 64'(busy), 64'd0);
    drainScoreboard("idle");

    // Free-running scroll of 1,2,3.
    k = cyc;
    bufQ.push_back(1); bufQ.push_back(2); bufQ.push_back(3);
    expStrobeQ.push_back(k + 5); expStrobeQ.push_back(k + 11); expStrobeQ.push_back(k + 17);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(20);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("run_segs", 64'(hex_segs), 64'(segs6(B, B, B, 7'h79, 7'h24, 7'h30)));
    waitCycles(10);
    drainScoreboard("run");

    // Single step with enable low.
    k = cyc;
    bufQ.push_back(10);
    expStrobeQ.push_back(k + 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(1);
    checkOutput("step_busy", 64'(busy), 64'd1);
    checkOutput("step_next_char", 64'(next_char), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("step_segs_before", 64'(hex_segs), 64'(segs6(B, B, B, 7'h79, 7'h24, 7'h30)));
    waitCycles(1);
    checkOutput("step_segs_after", 64'(hex_segs), 64'(segs6(B, B, 7'h79, 7'h24, 7'h30, 7'h08)));
    waitCycles(12);
    drainScoreboard("step");

    // Clear from idle, then enable dropped during the REQUEST cycle.
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("clear_idle_segs", 64'(hex_segs), 64'(segs6(B, B, B, B, B, B)));
    k = cyc;
    bufQ.push_back(7);
    expStrobeQ.push_back(k + 5);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(5);
    checkOutput("drop_next_char", 64'(next_char), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(2);
    checkOutput("drop_segs", 64'(hex_segs), 64'(segs6(B, B, B, B, B, 7'h78)));
    checkOutput("drop_busy", 64'(busy), 64'd0);
    waitCycles(12);
    drainScoreboard("drop");

    // Clear coinciding with CAPTURE discards the captured 5.
    k = cyc;
    bufQ.push_back(5); bufQ.push_back(9);
    expStrobeQ.push_back(k + 5); expStrobeQ.push_back(k + 11);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(6);
    checkOutput("capclr_busy", 64'(busy), 64'd1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitCycles(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("capclr_segs", 64'(hex_segs), 64'(segs6(B, B, B, B, B, B)));
    waitCycles(6);
    checkOutput("capclr_next_segs", 64'(hex_segs), 64'(segs6(B, B, B, B, B, 7'h10)));
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(10);
    drainScoreboard("capclr");

    // Seven steps of codes 0..6, then a dash with step held into REQUEST.
    for (int i = 0; i < 7; i++) begin
      k = cyc;
      bufQ.push_back(i);
      expStrobeQ.push_back(k + 1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      waitCycles(1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      waitCycles(3);
    end
    checkOutput("seven_segs", 64'(hex_segs), 64'(segs6(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02)));
    k = cyc;
    bufQ.push_back(17);
    expStrobeQ.push_back(k + 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(2);
    checkOutput("dash_segs", 64'(hex_segs), 64'(segs6(7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h3F)));
    waitCycles(10);
    drainScoreboard("seven");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/scroll_display_ctrl.md
Name: scroll_display_ctrl

Overview:
- Consumer stage for the scrolling character buffer.
- Periodically pulses next_char, captures the returned 5-bit character code and shifts it into a NUM_DIGITS-wide display register.
- Decodes each digit to active-low 7-segment patterns for the board HEX displays, giving a right-to-left scrolling message.
- Supports free-running scroll, single-step advance and clear.

Parameters:
- NUM_DIGITS, 6, number of 7-segment digits driven.
- SCROLL_PERIOD, 25_000_000, clk cycles between automatic advances (0.5 s at 50 MHz); legal range ≥ 4.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- enable  input  1  level; 1 = automatic scrolling runs
- step  input  1  single-cycle pulse; requests one immediate advance
- clear  input  1  single-cycle pulse; blanks display and restarts timing
- next_char  output  1  one-cycle read strobe to the buffer
- hex_char  input  5  character code from the buffer; registered there, valid the cycle after next_char
- hex_segs  output  NUM_DIGITS*7  active-low segments; digit 0 = rightmost, bits [6:0] = g..a
- busy  output  1  high in REQUEST and CAPTURE states

Behaviour:
- Character code: 0–15 → hex glyph 0–F; 16 → blank; 17 → dash; 18–31 → blank.
- Reset:
  - next_char = 0, busy = 0.
  - All digit codes = 16, so hex_segs = all ones.
  - Tick counter = 0; state = IDLE.
- Tick counter:
  - Width $clog2(SCROLL_PERIOD).
  - Counts only in WAIT; tick when count == SCROLL_PERIOD-1.
  - Counter returns to 0 on tick, on leaving WAIT, and on clear.
- FSM states: IDLE, WAIT, REQUEST, CAPTURE.
  - IDLE: enable = 1 → WAIT; step = 1 → REQUEST; step has priority if both are asserted.
  - WAIT:
    - tick → REQUEST.
    - step → REQUEST immediately; counter reset.
    - enable = 0 → IDLE.
  - REQUEST: next_char = 1 for exactly this cycle → CAPTURE unconditionally.
  - CAPTURE:
    - Sample hex_char and shift: digit[i] <= digit[i-1] for i = NUM_DIGITS-1..1, digit[0] <= hex_char; the oldest digit is discarded.
    - → WAIT if enable, else IDLE.
- Latency:
  - First next_char occurs SCROLL_PERIOD+1 cycles after enable rises from IDLE: 1 cycle IDLE→WAIT, SCROLL_PERIOD cycles in WAIT.
  - Successive strobes are SCROLL_PERIOD+2 cycles apart.
  - hex_segs reflects the new digit on the cycle after the CAPTURE edge; decode is combinational from registered codes.
- Boundaries:
  - enable falling during REQUEST/CAPTURE: the in-flight transfer still completes, so the buffer read pointer and display stay consistent; then → IDLE.
  - step during REQUEST/CAPTURE: ignored, not queued.
  - clear in any state: all digits = 16, counter = 0, next_char forced 0 that cycle.
    - State → WAIT if enable, else IDLE.
    - If clear coincides with CAPTURE, the captured character is discarded.
    - clear has priority over step and tick.
  - An empty buffer returns 0, so glyph "0" scrolls in; this is intended.
  - Only the 5-bit code is stored per digit; no other state.

Decomposition:
- Shared package scroll_pkg holds:
  - typedef char_code_t (logic [4:0]).
  - Constants CHAR_BLANK = 16 and CHAR_DASH = 17.
  - Typedef for the FSM state enum.
  - SEG_BLANK = 7'h7F.
- Sub-module seg7_decode: combinational char_code_t → active-low 7-bit pattern, instantiated NUM_DIGITS times via generate.

Test Plan:
- Reset, then idle 20 cycles with enable = 0 → next_char never asserted; hex_segs all ones; busy = 0.
- SCROLL_PERIOD = 4, enable = 1, buffer model returns 1,2,3 → next_char pulses at cycles 5, 11, 17 after enable rises; after the third capture, digit0 = 3 (7'h30), digit1 = 2 (7'h24), digit2 = 1 (7'h79), rest blank.
- step pulse with enable = 0, buffer returns 10 → one next_char the cycle after step; digit0 shows "A" (7'h08) two cycles after step; no further strobes.
- enable dropped in the REQUEST cycle → CAPTURE still shifts in the returned code, then IDLE; exactly one strobe observed.
- clear asserted in the CAPTURE cycle with hex_char = 5 → all digits blank next cycle, counter restarts, next strobe exactly SCROLL_PERIOD+1 cycles after clear with enable held 1.
- Seven captures with NUM_DIGITS = 6 and codes 0..6 → display shows 1..6 left to right; code 0 shifted out; code 17 renders a dash (7'h3F).
